// File: rtl/ifetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory over req/ack,
// buffers {inst, pc} pairs in a small FIFO and presents the head to the decoder.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [4:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        illegal,
  output logic        dbg_state
);

  // Handshake: a transfer completes in any cycle with imem_req && imem_ack; once
  // raised, imem_req and imem_addr stay put until that ack (reset excepted).
  // Decoder side: an entry is consumed in any cycle with inst_valid && inst_ready.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, DISCARD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   stale_addr;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          not_full, push, pop, enter_discard;

  assign not_full = count < DEPTH_C;

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    imem_addr     = fetch_pc;
    enter_discard = 1'b0;
    case (state_q)
      RUN: begin
        imem_req = not_full;
        // A redirect cannot cancel an unacked request; finish it on the old address.
        if (redirect && not_full && !imem_ack) begin
          state_d       = DISCARD;
          enter_discard = 1'b1;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = stale_addr;
        if (imem_ack) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) imem_req = 1'b0;
  end

  assign push       = (state_q == RUN) && imem_req && imem_ack && !redirect;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc   <= RESET_PC;
      stale_addr <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state_q <= state_d;
      if (enter_discard) stale_addr <= fetch_pc;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc + 32'd4;
          wr_ptr   <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

  assign inst      = inst_valid ? inst_mem[rd_ptr] : 32'h0000_0013;
  assign inst_pc   = inst_valid ? pc_mem[rd_ptr] : 32'h0000_0000;
  assign opcode    = inst[6:2];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign illegal   = inst_valid && (inst[1:0] != 2'b11);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer against a queue-based fetch model.
module tb_ifetch_buffer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;
  logic        dbg_state;

  ifetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: buffered {inst, pc} entries, next fetch address, and
  // whether an abandoned request is still owed an ack
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_owed;
  logic [31:0] m_owed_addr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: address-derived words; address 0x..54 holds a non-32-bit encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b11} ^ 32'h1357_9000;
    if (a[7:0] == 8'h54) w[1:0] = 2'b01;
    return w;
  endfunction

  function automatic logic m_req();
    return m_owed || (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_owed ? m_owed_addr : m_pc;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc   = RESET_PC;
    m_owed = 1'b0;
    m_owed_addr = RESET_PC;
  endtask

  task automatic compare_all();
    logic [31:0] e_inst, e_pc;
    logic        e_valid;
    e_valid = exp_q.size() > 0;
    e_inst  = e_valid ? exp_q[0][63:32] : 32'h0000_0013;
    e_pc    = e_valid ? exp_q[0][31:0] : 32'h0;
    check("inst_valid", 32'(inst_valid), 32'(e_valid));
    check("inst", inst, e_inst);
    check("inst_pc", inst_pc, e_pc);
    check("opcode", 32'(opcode), 32'(e_inst[6:2]));
    check("funct3", 32'(funct3), 32'(e_inst[14:12]));
    check("funct7", 32'(funct7), 32'(e_inst[31:25]));
    check("illegal", 32'(illegal), 32'(e_valid && e_inst[1:0] != 2'b11));
    check("imem_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) check("imem_addr", imem_addr, m_addr());
  endtask

  // driver: one clock of stimulus, model step on the edge, compare at negedge
  task automatic cycle(input logic ack_i, input logic redir_i, input logic [31:0] rpc_i,
                       input logic rdy_i);
    logic        req, valid, done;
    logic [31:0] word;
    imem_ack    = ack_i;
    imem_rdata  = mem_word(imem_addr);
    redirect    = redir_i;
    redirect_pc = rpc_i;
    inst_ready  = rdy_i;
    req   = m_req();
    valid = exp_q.size() > 0;
    done  = req && ack_i;
    word  = mem_word(m_addr());
    @(posedge clk);
    if (redir_i) begin
      exp_q.delete();
      if (m_owed) m_owed = !done;
      else if (req && !ack_i) begin
        m_owed      = 1'b1;
        m_owed_addr = m_pc;
      end
      m_pc = {rpc_i[31:2], 2'b00};
    end else begin
      if (valid && rdy_i) void'(exp_q.pop_front());
      if (m_owed) begin
        if (done) m_owed = 1'b0;
      end else if (done) begin
        exp_q.push_back({word, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; inst_ready = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    rst = 1'b0;
    #1 compare_all();

    // zero-wait memory, decoder always ready: one instruction per cycle
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1);
    // decoder stalled: FIFO fills, request drops, head held
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1);

    // 3-cycle latency memory with a redirect to 0x100 while 0x8 is outstanding
    cycle(1, 1, 32'h8, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h100, 1);
    check("held_addr", imem_addr, 32'h8);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("post_discard_addr", imem_addr, 32'h100);
    cycle(1, 0, 0, 1);
    check("first_pc_after", inst_pc, 32'h100);
    cycle(1, 0, 0, 1);

    // redirect coinciding with ack and ready: acked word is dropped
    cycle(1, 1, 32'h203, 1);
    check("flush_valid", 32'(inst_valid), 32'h0);
    check("flush_addr", imem_addr, 32'h200);
    cycle(1, 0, 0, 1);

    // PC wrap and a non-32-bit encoding at the head
    cycle(1, 1, 32'hFFFF_FFFC, 1);
    cycle(1, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0);
    cycle(1, 1, 32'h54, 0);
    cycle(1, 0, 0, 0);
    check("illegal_head", 32'(illegal), 32'h1);
    cycle(0, 0, 0, 0);

    // reset asserted asynchronously with a request outstanding
    cycle(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_valid", 32'(inst_valid), 32'h0);
    check("arst_inst", inst, 32'h0000_0013);
    check("arst_addr", imem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 compare_all();
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);

    // random traffic: variable ack latency, stalls and redirects
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 1023));
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, rpc,
            $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
